// File: rtl/boss_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module     : boss_ctrl_if
//  Purpose    : Bundles the game-side inputs and boss-side outputs exchanged
//               between the stage-3 boss controller and its environment.
//  Ports      : state[3:0]      game state
//               tick            one-cycle pulse per video frame
//               player_x/y[8:0] player top-left position
//               hit             player attack overlaps the boss
//               boss_x/y[8:0]   boss top-left position
//               boss_state[3:0] sprite-sheet frame index
//               boss_hp[3:0]    remaining hit points
//               boss_dead       boss is in its dead pose
//  Revision   : 1.0  initial release
// ============================================================================
interface boss_ctrl_if;
   logic [3:0] state;
   logic       tick;
   logic [8:0] player_x;
   logic [8:0] player_y;
   logic       hit;
   logic [8:0] boss_x;
   logic [8:0] boss_y;
   logic [3:0] boss_state;
   logic [3:0] boss_hp;
   logic       boss_dead;

   // Game side drives the controls and observes the boss.
   modport master (
      output state, tick, player_x, player_y, hit,
      input  boss_x, boss_y, boss_state, boss_hp, boss_dead
   );

   // Boss controller side.
   modport slave (
      input  state, tick, player_x, player_y, hit,
      output boss_x, boss_y, boss_state, boss_hp, boss_dead
   );
endinterface
`default_nettype wire

// File: rtl/boss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : boss_ctrl
//  Purpose    : Stage-3 boss controller. Chases the player one pixel per
//               MOVE_DIV frames, takes hits, plays walk / hurt / death
//               animations, and runs the idle animation outside stage 3.
//  Ports      : clk   system clock
//               rst   synchronous active-high reset
//               bus   boss_ctrl_if.slave (game inputs, registered boss outputs)
//  Revision   : 1.0  initial release
// ============================================================================
module boss_ctrl #(
   parameter int SPAWN_X    = 150,
   parameter int SPAWN_Y    = 40,
   parameter int HP_MAX     = 5,
   parameter int MOVE_DIV   = 2,
   parameter int ANIM_DIV   = 8,
   parameter int HURT_TICKS = 30,
   parameter int X_MAX      = 310,
   parameter int Y_MAX      = 230
) (
   input  logic        clk,
   input  logic        rst,
   boss_ctrl_if.slave  bus
);

   localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

   localparam logic [3:0] C_STAGE3  = 4'd6;
   localparam logic [8:0] C_SPAWN_X = 9'(SPAWN_X);
   localparam logic [8:0] C_SPAWN_Y = 9'(SPAWN_Y);
   localparam logic [8:0] C_X_MAX   = 9'(X_MAX);
   localparam logic [8:0] C_Y_MAX   = 9'(Y_MAX);
   localparam logic [3:0] C_HP_MAX  = 4'(HP_MAX);
   localparam logic [7:0] C_HURT    = 8'(HURT_TICKS);
   localparam logic [AW-1:0] C_ANIM_LAST = AW'(ANIM_DIV - 1);
   localparam logic [MW-1:0] C_MOVE_LAST = MW'(MOVE_DIV - 1);

   localparam logic [3:0] C_FRAME_WALK  = 4'd4;
   localparam logic [3:0] C_FRAME_HURT  = 4'd8;
   localparam logic [3:0] C_FRAME_DIE0  = 4'd9;
   localparam logic [3:0] C_FRAME_DIE2  = 4'd11;

   typedef enum logic [2:0] {
      S_OFF   = 3'd0,
      S_CHASE = 3'd1,
      S_HURT  = 3'd2,
      S_DYING = 3'd3,
      S_DEAD  = 3'd4
   } fsm_t;

   fsm_t          r_fsm,      w_fsm_nxt;
   logic [8:0]    r_x,        w_x_nxt;
   logic [8:0]    r_y,        w_y_nxt;
   logic [3:0]    r_frame,    w_frame_nxt;
   logic [3:0]    r_hp,       w_hp_nxt;
   logic          r_dead,     w_dead_nxt;
   logic [AW-1:0] r_anim_cnt, w_anim_nxt;
   logic [MW-1:0] r_move_cnt, w_move_nxt;
   logic [7:0]    r_hurt_cnt, w_hurt_nxt;
   logic          r_in_stage3;

   logic          w_stage3;
   logic          w_anim_wrap;
   logic [8:0]    w_tgt_x,  w_tgt_y;
   logic [8:0]    w_step_x, w_step_y;

   assign w_stage3    = (bus.state == C_STAGE3);
   assign w_anim_wrap = (r_anim_cnt == C_ANIM_LAST);

   // Chase target is the player position limited to the on-screen range, so
   // a single-pixel step toward it can never leave [0, MAX].
   assign w_tgt_x = (bus.player_x > C_X_MAX) ? C_X_MAX : bus.player_x;
   assign w_tgt_y = (bus.player_y > C_Y_MAX) ? C_Y_MAX : bus.player_y;

   always_comb begin
      w_step_x = r_x;
      if (r_x < w_tgt_x)      w_step_x = r_x + 9'd1;
      else if (r_x > w_tgt_x) w_step_x = r_x - 9'd1;
      if (w_step_x > C_X_MAX) w_step_x = C_X_MAX;

      w_step_y = r_y;
      if (r_y < w_tgt_y)      w_step_y = r_y + 9'd1;
      else if (r_y > w_tgt_y) w_step_y = r_y - 9'd1;
      if (w_step_y > C_Y_MAX) w_step_y = C_Y_MAX;
   end

   // Next-state and output logic. Priority: leaving stage 3, entering
   // stage 3, hit, tick.
   always_comb begin
      w_fsm_nxt   = r_fsm;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_frame_nxt = r_frame;
      w_hp_nxt    = r_hp;
      w_dead_nxt  = r_dead;
      w_anim_nxt  = r_anim_cnt;
      w_move_nxt  = r_move_cnt;
      w_hurt_nxt  = r_hurt_cnt;

      if (!w_stage3) begin
         w_dead_nxt = 1'b0;
         if (r_fsm != S_OFF) begin
            // Restart the idle animation from its first frame.
            w_fsm_nxt   = S_OFF;
            w_frame_nxt = 4'd0;
            w_anim_nxt  = '0;
         end else if (bus.tick) begin
            if (w_anim_wrap) begin
               w_anim_nxt  = '0;
               w_frame_nxt = {2'b00, r_frame[1:0] + 2'd1};
            end else begin
               w_anim_nxt  = r_anim_cnt + AW'(1);
            end
         end
      end else if (!r_in_stage3) begin
         w_fsm_nxt   = S_CHASE;
         w_x_nxt     = C_SPAWN_X;
         w_y_nxt     = C_SPAWN_Y;
         w_hp_nxt    = C_HP_MAX;
         w_frame_nxt = C_FRAME_WALK;
         w_dead_nxt  = 1'b0;
         w_anim_nxt  = '0;
         w_move_nxt  = '0;
         w_hurt_nxt  = '0;
      end else begin
         case (r_fsm)
            S_CHASE: begin
               if (bus.hit) begin
                  if (r_hp <= 4'd1) begin
                     w_hp_nxt    = 4'd0;
                     w_fsm_nxt   = S_DYING;
                     w_frame_nxt = C_FRAME_DIE0;
                     w_anim_nxt  = '0;
                  end else begin
                     w_hp_nxt    = r_hp - 4'd1;
                     w_fsm_nxt   = S_HURT;
                     w_frame_nxt = C_FRAME_HURT;
                     w_hurt_nxt  = C_HURT;
                  end
               end else if (bus.tick) begin
                  if (r_move_cnt == C_MOVE_LAST) begin
                     w_move_nxt = '0;
                     w_x_nxt    = w_step_x;
                     w_y_nxt    = w_step_y;
                  end else begin
                     w_move_nxt = r_move_cnt + MW'(1);
                  end
                  if (w_anim_wrap) begin
                     w_anim_nxt  = '0;
                     w_frame_nxt = {2'b01, r_frame[1:0] + 2'd1};
                  end else begin
                     w_anim_nxt  = r_anim_cnt + AW'(1);
                  end
               end
            end
            S_HURT: begin
               if (bus.tick) begin
                  if (r_hurt_cnt <= 8'd1) begin
                     w_hurt_nxt  = 8'd0;
                     w_fsm_nxt   = S_CHASE;
                     w_frame_nxt = C_FRAME_WALK;
                     w_move_nxt  = '0;
                     w_anim_nxt  = '0;
                  end else begin
                     w_hurt_nxt  = r_hurt_cnt - 8'd1;
                  end
               end
            end
            S_DYING: begin
               if (bus.tick) begin
                  if (w_anim_wrap) begin
                     w_anim_nxt = '0;
                     if (r_frame >= C_FRAME_DIE2) begin
                        w_fsm_nxt   = S_DEAD;
                        w_frame_nxt = C_FRAME_DIE2;
                        w_dead_nxt  = 1'b1;
                     end else begin
                        w_frame_nxt = r_frame + 4'd1;
                     end
                  end else begin
                     w_anim_nxt = r_anim_cnt + AW'(1);
                  end
               end
            end
            S_DEAD: begin
               w_frame_nxt = C_FRAME_DIE2;
               w_dead_nxt  = 1'b1;
            end
            default: begin
               w_fsm_nxt = r_fsm;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm       <= S_OFF;
         r_x         <= C_SPAWN_X;
         r_y         <= C_SPAWN_Y;
         r_frame     <= 4'd0;
         r_hp        <= C_HP_MAX;
         r_dead      <= 1'b0;
         r_anim_cnt  <= '0;
         r_move_cnt  <= '0;
         r_hurt_cnt  <= '0;
         // Cleared so stage 3 held through reset counts as a fresh entry.
         r_in_stage3 <= 1'b0;
      end else begin
         r_fsm       <= w_fsm_nxt;
         r_x         <= w_x_nxt;
         r_y         <= w_y_nxt;
         r_frame     <= w_frame_nxt;
         r_hp        <= w_hp_nxt;
         r_dead      <= w_dead_nxt;
         r_anim_cnt  <= w_anim_nxt;
         r_move_cnt  <= w_move_nxt;
         r_hurt_cnt  <= w_hurt_nxt;
         r_in_stage3 <= w_stage3;
      end
   end

   assign bus.boss_x     = r_x;
   assign bus.boss_y     = r_y;
   assign bus.boss_state = r_frame;
   assign bus.boss_hp    = r_hp;
   assign bus.boss_dead  = r_dead;

endmodule
`default_nettype wire
